sram_like_mo: RTL and testbench

Multi-outstanding CPU-to-SRAM-like bridge, parametrised in transaction depth. It sits between a CPU memory port (instruction or data) and the SRAM-like-to-AXI converter. It registers one request at a time toward the slave and tracks up to MAX_OUT accepted-but-unanswered transactions in an in-order tracking FIFO. On flush, the bridge keeps the bus protocol legal and silently discards responses that belong to flushed transactions.

---
 rtl/sram_like_mo.sv | 196 +++++++++++++++++++
 tb/tb_sram_like_mo.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_mo.sv
// sram_like_mo: multi-outstanding CPU-to-SRAM-like bridge.
//   It holds one request at a time toward the slave. Up to MAX_OUT requests that
//   are past addr_ok and still waiting for data_ok are tracked in an in-order FIFO.
//   Flush marks every tracked and pending transaction as discard. Bus handshakes
//   stay legal, and the responses of those transactions are dropped silently.
// Optional feature (macro SRAM_LIKE_MO_RALIGN_EN):
//   When defined, read data is right-aligned by the byte offset stored in the FIFO.
//   When undefined, raw rdata is returned and no offset is stored.
// Ports:
//   clk, resetn                      clock and asynchronous active-low reset
//   cpu_req/wr/sel/addr/wdata        CPU request; cpu_ready accepts it
//   flush                            discard all not-yet-returned transactions
//   cpu_resp_valid/wr/rdata          registered one-cycle response
//   busy                             request held or transactions outstanding
//   req/wr/size/addr/wdata           SRAM-like request toward the slave
//   addr_ok/data_ok/rdata            slave handshakes and read data
module sram_like_mo #(
    parameter int unsigned MAX_OUT = 2,
    parameter int unsigned CNT_W   = $clog2(MAX_OUT) + 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [3:0]  cpu_sel,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ready,
    input  logic        flush,
    output logic        cpu_resp_valid,
    output logic        cpu_resp_wr,
    output logic [31:0] cpu_resp_rdata,
    output logic        busy,
    output logic        req,
    output logic        wr,
    output logic [1:0]  size,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic        addr_ok,
    input  logic        data_ok,
    input  logic [31:0] rdata
);

    localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               pend_disc;
    logic               fifo_wr   [MAX_OUT];
    logic               fifo_disc [MAX_OUT];
`ifdef SRAM_LIKE_MO_RALIGN_EN
    logic [1:0]         fifo_off  [MAX_OUT];
`endif
    logic               accept;
    logic               push;
    logic               pop;
    logic               resp_take;
    logic [31:0]        rdata_fmt;
    logic [3:0]         sel_dec;
    logic               unused_addr_lsb;

    // Byte enables -> {size, byte offset}
    function automatic logic [3:0] sel_decode(input logic [3:0] sel);
        case (sel)
            4'b0001: return {2'd0, 2'd0};
            4'b0010: return {2'd0, 2'd1};
            4'b0100: return {2'd0, 2'd2};
            4'b1000: return {2'd0, 2'd3};
            4'b0011: return {2'd1, 2'd0};
            4'b1100: return {2'd1, 2'd2};
            default: return {2'd2, 2'd0};
        endcase
    endfunction

    // Pointer increment with explicit wrap, so it also works when MAX_OUT is 1
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign sel_dec         = sel_decode(cpu_sel);
    assign unused_addr_lsb = ^cpu_addr[1:0];

    assign req       = (state == PEND);
    assign busy      = (state == PEND) | (cnt != '0);
    assign cpu_ready = (state == IDLE) & (cnt < CNT_W'(MAX_OUT)) & ~flush;
    assign accept    = cpu_req & cpu_ready;
    assign push      = (state == PEND) & addr_ok;
    // data_ok with nothing outstanding is a protocol violation and is ignored
    assign pop       = data_ok & (cnt != '0);
    // A flush in the same cycle as data_ok also discards the popped entry
    assign resp_take = pop & ~(fifo_disc[rd_ptr] | flush);

`ifdef SRAM_LIKE_MO_RALIGN_EN
    assign rdata_fmt = rdata >> {fifo_off[rd_ptr], 3'b000};
`else
    assign rdata_fmt = rdata;
`endif

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a pending request is never withdrawn, even on flush
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = PEND;
            PEND: if (addr_ok) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request register; pend_disc remembers a flush that hit a pending request
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr        <= 1'b0;
            size      <= 2'd0;
            addr      <= 32'd0;
            wdata     <= 32'd0;
            pend_disc <= 1'b0;
        end else if (accept) begin
            wr        <= cpu_wr;
            size      <= sel_dec[3:2];
            addr      <= {cpu_addr[31:2], sel_dec[1:0]};
            wdata     <= cpu_wdata;
            pend_disc <= 1'b0;
        end else if (flush && state == PEND) begin
            pend_disc <= 1'b1;
        end
    end

    // In-order tracking FIFO and outstanding counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < int'(MAX_OUT); i++) begin
                fifo_wr[i]   <= 1'b0;
                fifo_disc[i] <= 1'b0;
`ifdef SRAM_LIKE_MO_RALIGN_EN
                fifo_off[i]  <= 2'd0;
`endif
            end
        end else begin
            if (flush) begin
                for (int i = 0; i < int'(MAX_OUT); i++) begin
                    fifo_disc[i] <= 1'b1;
                end
            end
            if (push) begin
                fifo_wr[wr_ptr]   <= wr;
                fifo_disc[wr_ptr] <= flush | pend_disc;
`ifdef SRAM_LIKE_MO_RALIGN_EN
                fifo_off[wr_ptr]  <= addr[1:0];
`endif
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                cnt <= cnt + CNT_W'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Registered response; write and discarded responses carry zero data
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cpu_resp_valid <= 1'b0;
            cpu_resp_wr    <= 1'b0;
            cpu_resp_rdata <= 32'd0;
        end else begin
            cpu_resp_valid <= resp_take;
            cpu_resp_wr    <= resp_take & fifo_wr[rd_ptr];
            cpu_resp_rdata <= (resp_take && !fifo_wr[rd_ptr]) ? rdata_fmt : 32'd0;
        end
    end

endmodule

// File: tb/tb_sram_like_mo.sv
// tb_sram_like_mo: self-checking bench for sram_like_mo.
//   The reference model tracks the held request and an in-order queue of
//   outstanding transactions. Every cycle it predicts the DUT outputs.
//   Directed scenarios come first, followed by randomized traffic that
//   includes a mid-run reset.
module tb_sram_like_mo;

    localparam int unsigned MAX_OUT = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cpu_req;
    logic        cpu_wr;
    logic [3:0]  cpu_sel;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic        flush;
    logic        cpu_resp_valid;
    logic        cpu_resp_wr;
    logic [31:0] cpu_resp_rdata;
    logic        busy;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    sram_like_mo #(.MAX_OUT(MAX_OUT)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .cpu_req        (cpu_req),
        .cpu_wr         (cpu_wr),
        .cpu_sel        (cpu_sel),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_ready      (cpu_ready),
        .flush          (flush),
        .cpu_resp_valid (cpu_resp_valid),
        .cpu_resp_wr    (cpu_resp_wr),
        .cpu_resp_rdata (cpu_resp_rdata),
        .busy           (busy),
        .req            (req),
        .wr             (wr),
        .size           (size),
        .addr           (addr),
        .wdata          (wdata),
        .addr_ok        (addr_ok),
        .data_ok        (data_ok),
        .rdata          (rdata)
    );

    typedef struct packed {
        logic       wr;
        logic       disc;
        logic [1:0] off;
    } ent_t;

    ent_t        mq[$];
    logic        m_pend;
    logic        m_wr;
    logic        m_pdisc;
    logic [1:0]  m_size;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_rv;
    logic        m_rwr;
    logic [31:0] m_rdata;
    int          n_chk  = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Byte enables -> size and offset, written from the single-byte / half / word rules
    task automatic sel_model(input logic [3:0] s, output logic [1:0] sz, output logic [1:0] of);
        if ($countones(s) == 1) begin
            sz = 2'd0;
            of = s[0] ? 2'd0 : s[1] ? 2'd1 : s[2] ? 2'd2 : 2'd3;
        end else if (s == 4'b0011) begin
            sz = 2'd1;
            of = 2'd0;
        end else if (s == 4'b1100) begin
            sz = 2'd1;
            of = 2'd2;
        end else begin
            sz = 2'd2;
            of = 2'd0;
        end
    endtask

    function automatic logic [31:0] m_align(input logic [31:0] d, input logic [1:0] off);
`ifdef SRAM_LIKE_MO_RALIGN_EN
        return d >> (8 * int'(off));
`else
        return (off == 2'd0) ? d : d;
`endif
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pend  = 1'b0;
        m_wr    = 1'b0;
        m_pdisc = 1'b0;
        m_size  = 2'd0;
        m_addr  = 32'd0;
        m_wdata = 32'd0;
        m_rv    = 1'b0;
        m_rwr   = 1'b0;
        m_rdata = 32'd0;
    endtask

    // One clock cycle: drive inputs at the falling edge, check outputs, advance the model
    task automatic cyc(input logic rq, input logic w, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] wd, input logic fl,
                       input logic aok, input logic dok, input logic [31:0] rd);
        logic       rdy;
        ent_t       e;
        logic [1:0] sz;
        logic [1:0] of;
        cpu_req   = rq;
        cpu_wr    = w;
        cpu_sel   = s;
        cpu_addr  = a;
        cpu_wdata = wd;
        flush     = fl;
        addr_ok   = aok;
        data_ok   = dok;
        rdata     = rd;
        #1;
        rdy = !m_pend && (mq.size() < int'(MAX_OUT)) && !fl;
        chk("cpu_ready", 32'(cpu_ready), 32'(rdy));
        chk("req", 32'(req), 32'(m_pend));
        chk("busy", 32'(busy), 32'(m_pend || mq.size() != 0));
        chk("resp_valid", 32'(cpu_resp_valid), 32'(m_rv));
        if (m_pend) begin
            chk("wr", 32'(wr), 32'(m_wr));
            chk("size", 32'(size), 32'(m_size));
            chk("addr", addr, m_addr);
            chk("wdata", wdata, m_wdata);
        end
        if (m_rv) begin
            chk("resp_wr", 32'(cpu_resp_wr), 32'(m_rwr));
            chk("resp_rdata", cpu_resp_rdata, m_rdata);
        end
        if (dok && mq.size() != 0) begin
            e       = mq.pop_front();
            m_rv    = !(e.disc || fl);
            m_rwr   = m_rv && e.wr;
            m_rdata = (m_rv && !e.wr) ? m_align(rd, e.off) : 32'd0;
        end else begin
            m_rv    = 1'b0;
            m_rwr   = 1'b0;
            m_rdata = 32'd0;
        end
        if (fl) begin
            foreach (mq[i]) mq[i].disc = 1'b1;
            if (m_pend) m_pdisc = 1'b1;
        end
        if (m_pend && aok) begin
            mq.push_back('{wr: m_wr, disc: m_pdisc, off: m_addr[1:0]});
            m_pend = 1'b0;
        end else if (rq && rdy) begin
            sel_model(s, sz, of);
            m_pend  = 1'b1;
            m_wr    = w;
            m_size  = sz;
            m_addr  = {a[31:2], of};
            m_wdata = wd;
            m_pdisc = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic do_reset();
        cpu_req = 1'b0;
        flush   = 1'b0;
        addr_ok = 1'b0;
        data_ok = 1'b0;
        resetn  = 1'b0;
        #1;
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_resp_valid", 32'(cpu_resp_valid), 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_cpu_ready", 32'(cpu_ready), 32'd1);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        resetn    = 1'b0;
        cpu_req   = 1'b0;
        cpu_wr    = 1'b0;
        cpu_sel   = 4'h0;
        cpu_addr  = 32'd0;
        cpu_wdata = 32'd0;
        flush     = 1'b0;
        addr_ok   = 1'b0;
        data_ok   = 1'b0;
        rdata     = 32'd0;
        model_reset();
        @(negedge clk);
        do_reset();
        idle(1);

        // Single word read with minimum latency
        cyc(1'b1, 1'b0, 4'hF, 32'h1000, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("s1_req", 32'(req), 32'd1);
        chk("s1_size", 32'(size), 32'd2);
        chk("s1_addr", addr, 32'h0000_1000);
        cyc(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        chk("s1_resp_valid", 32'(cpu_resp_valid), 32'd1);
        chk("s1_resp_rdata", cpu_resp_rdata, 32'hDEAD_BEEF);
        idle(1);

        // Third read blocked while MAX_OUT are outstanding; in-order responses
        cyc(1'b1, 1'b0, 4'hF, 32'h100, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
        cyc(1'b1, 1'b0, 4'hF, 32'h104, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
        cpu_req = 1'b1;
        #1;
        chk("s2_ready_blocked", 32'(cpu_ready), 32'd0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 4'hF, 32'h108, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        cyc(1'b1, 1'b0, 4'hF, 32'h108, 32'd0, 1'b0, 1'b0, 1'b1, 32'hAAAA_0001);
        chk("s2_resp0", cpu_resp_rdata, 32'hAAAA_0001);
        cyc(1'b1, 1'b0, 4'hF, 32'h108, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("s2_third_issued", addr, 32'h0000_0108);
        // addr_ok and data_ok together with one outstanding
        cyc(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'hBBBB_0002);
        chk("s2_resp1", cpu_resp_rdata, 32'hBBBB_0002);
        chk("s5_busy_after_swap", 32'(busy), 32'd1);
        cyc(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'hCCCC_0003);
        chk("s2_resp2", cpu_resp_rdata, 32'hCCCC_0003);
        idle(1);

        // Byte store
        cyc(1'b1, 1'b1, 4'b0100, 32'h2003, 32'h00AB_0000, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("s3_wr", 32'(wr), 32'd1);
        chk("s3_size", 32'(size), 32'd0);
        chk("s3_addr", addr, 32'h0000_2002);
        chk("s3_wdata", wdata, 32'h00AB_0000);
        cyc(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        chk("s3_resp_wr", 32'(cpu_resp_wr), 32'd1);
        chk("s3_resp_rdata", cpu_resp_rdata, 32'd0);
        idle(1);

        // Flush with one outstanding and one pending request
        cyc(1'b1, 1'b0, 4'hF, 32'h300, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
        cyc(1'b1, 1'b0, 4'hF, 32'h304, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        cyc(1'b1, 1'b0, 4'hF, 32'h308, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0);
        idle(3);
        chk("s4_req_held", 32'(req), 32'd1);
        cyc(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h1111_1111);
        chk("s4_no_resp0", 32'(cpu_resp_valid), 32'd0);
        cyc(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h2222_2222);
        chk("s4_no_resp1", 32'(cpu_resp_valid), 32'd0);
        chk("s4_busy_low", 32'(busy), 32'd0);
        idle(1);

        // Byte read at offset 1
        cyc(1'b1, 1'b0, 4'b0010, 32'h400, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h1122_3344);
`ifdef SRAM_LIKE_MO_RALIGN_EN
        chk("s6_byte_read", cpu_resp_rdata, 32'h0011_2233);
`else
        chk("s6_byte_read", cpu_resp_rdata, 32'h1122_3344);
`endif

        // Reset in the middle of a transaction drops it
        cyc(1'b1, 1'b0, 4'hF, 32'h500, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
        do_reset();
        cyc(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h5555_5555);
        chk("rst_drop_resp", 32'(cpu_resp_valid), 32'd0);

        // Randomized traffic, including protocol-violating handshakes and a reset
        for (int k = 0; k < 3000; k++) begin
            if (k == 1500) do_reset();
            cyc(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)), 4'($urandom),
                $urandom, $urandom, 1'($urandom_range(0, 19) == 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 4), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
